// File: rtl/sistema_svsd_mux_if.sv
// Avalon-MM register-port bundle for the seven-segment scan controller.
// Latency: none (wires only); readdata is produced combinationally by the slave.
// Backpressure: none; every chipselect/write_n access completes in one cycle.
interface sistema_svsd_mux_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sistema_svsd_mux.sv
// Multiplexed seven-segment driver: per-digit nibbles, enable/blink/dp masks, hex decode, digit scan.
// Latency: register writes and index changes reach seg/dig_sel one clk later; readdata is combinational.
// Backpressure: none; the slave accepts every write in the cycle it is strobed.
module sistema_svsd_mux #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sistema_svsd_mux_if.slave      bus,
    output logic [7:0]             seg,
    output logic [NUM_DIGITS-1:0]  dig_sel
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Inactive output levels; blanked digits and reset both drive these.
    localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Register file
    logic [DW-1:0]         r_data;
    logic [NUM_DIGITS-1:0] r_enable;
    logic [NUM_DIGITS-1:0] r_blink;
    logic [NUM_DIGITS-1:0] r_dp;

    // Scan state
    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_frame;
    logic          r_blink_phase;

    // Output registers
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_sel;

    logic                  w_wr;
    logic                  w_tick;
    logic                  w_idx_wrap;
    logic [2:0]            w_nib_idx;
    logic [3:0]            w_nib;
    logic                  w_en;
    logic                  w_blk;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_blank;
    logic [7:0]            w_seg_act;
    logic [NUM_DIGITS-1:0] w_sel_act;
    logic                  w_unused;

    assign w_wr       = bus.chipselect && !bus.write_n;
    assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_wrap = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_nib_idx  = bus.writedata[10:8];
    assign w_unused   = &{1'b0, bus.writedata};

    assign seg     = r_seg;
    assign dig_sel = r_sel;

    // Active-high segment pattern for one hex nibble (a..g on bits 0..6).
    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 7'h3F;
            4'h1: f_hex = 7'h06;
            4'h2: f_hex = 7'h5B;
            4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66;
            4'h5: f_hex = 7'h6D;
            4'h6: f_hex = 7'h7D;
            4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h6F;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39;
            4'hD: f_hex = 7'h5E;
            4'hE: f_hex = 7'h79;
            default: f_hex = 7'h71;
        endcase
    endfunction

    // Register writes; NIBBLE updates one DATA digit and ignores indices past the last digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_enable <= '1;
            r_blink  <= '0;
            r_dp     <= '0;
        end else if (w_wr) begin
            case (bus.address)
                3'd0: r_data   <= bus.writedata[DW-1:0];
                3'd1: r_enable <= bus.writedata[NUM_DIGITS-1:0];
                3'd2: r_blink  <= bus.writedata[NUM_DIGITS-1:0];
                3'd3: r_dp     <= bus.writedata[NUM_DIGITS-1:0];
                3'd4: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_nib_idx == 3'(i)) begin
                            r_data[i*4 +: 4] <= bus.writedata[3:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read mux; NIBBLE and the spare addresses read as zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0: bus.readdata[DW-1:0]         = r_data;
            3'd1: bus.readdata[NUM_DIGITS-1:0] = r_enable;
            3'd2: bus.readdata[NUM_DIGITS-1:0] = r_blink;
            3'd3: bus.readdata[NUM_DIGITS-1:0] = r_dp;
            default: ;
        endcase
    end

    // Slot prescaler, digit index and frame/blink-phase counters advance together on each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_idx_wrap) begin
                if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    // Pick the current digit's state and build the active-high segment/select pattern.
    always_comb begin
        w_nib    = '0;
        w_en     = 1'b0;
        w_blk    = 1'b0;
        w_dp     = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_data[i*4 +: 4];
                w_en        = r_enable[i];
                w_blk       = r_blink[i];
                w_dp        = r_dp[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_blank   = !w_en || (w_blk && r_blink_phase);
        w_seg_act = w_blank ? 8'h00 : {w_dp, f_hex(w_nib)};
        w_sel_act = w_blank ? '0 : w_onehot;
    end

    // Register the pins at the requested polarity; reset forces them inactive immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= SEG_OFF;
            r_sel <= SEL_OFF;
        end else begin
            r_seg <= ACTIVE_LOW ? ~w_seg_act : w_seg_act;
            r_sel <= ACTIVE_LOW ? ~w_sel_act : w_sel_act;
        end
    end

endmodule

// File: tb/tb_sistema_svsd_mux.sv
// Directed bench for sistema_svsd_mux: 6 digits, 2-clk slots, 1-frame blink period, active-low pins.
// Latency: 12-clk scan frame; outputs sampled 1ns after each rising edge.
// Backpressure: none; bus writes are single-cycle strobes.
module tb_sistema_svsd_mux;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] seg;
    logic [5:0] dig_sel;
    int         cyc;
    int         n_checks = 0;
    int         n_fail = 0;

    sistema_svsd_mux_if bus ();

    sistema_svsd_mux #(
        .NUM_DIGITS   (6),
        .SCAN_DIV     (2),
        .BLINK_FRAMES (1),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    always #5 clk = ~clk;

    // Edges since reset release: outputs after edge k show digit ((k-1)/2)%6 of frame (k-1)/12.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Active-low segment codes for hex 0..F with dp off.
    logic [7:0] hex_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // Active-low one-hot selects for digits 0..5.
    logic [5:0] sel_lo [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Advance until (cyc-1) % m == t; an expired budget is a failure.
    task automatic wait_for(input int m, input int t);
        int n = 0;
        while (((cyc - 1) % m) != t && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (((cyc - 1) % m) != t) begin
            n_fail++;
            $display("FAIL wait_for m=%0d t=%0d: cyc=%0d not reached", m, t, cyc);
        end
    endtask

    task automatic test_reset();
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", seg); end
        n_checks++; if (dig_sel !== 6'h3F) begin n_fail++; $display("FAIL reset_sel: got %h want 3f", dig_sel); end
        bus.address = 3'd1; #1;
        n_checks++; if (bus.readdata !== 32'h3F) begin n_fail++; $display("FAIL reset_enable: got %h want 3f", bus.readdata); end
        bus.address = 3'd0; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.readdata); end
        step();
        step();
        reset_n = 1'b1;
        step();
        n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL release_seg: got %h want c0", seg); end
        n_checks++; if (dig_sel !== 6'h3E) begin n_fail++; $display("FAIL release_sel: got %h want 3e", dig_sel); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_seg [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        bus_write(3'd0, 32'h00FE_DCBA);
        step();
        wait_for(12, 0);
        for (int j = 0; j < 13; j++) begin
            int d = (j / 2) % 6;
            n_checks++;
            if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL scan_seg j=%0d: got %h want %h", j, seg, exp_seg[d]); end
            n_checks++;
            if (dig_sel !== sel_lo[d]) begin n_fail++; $display("FAIL scan_sel j=%0d: got %h want %h", j, dig_sel, sel_lo[d]); end
            step();
        end
    endtask

    task automatic test_nibble_decode();
        for (int v = 0; v < 16; v++) begin
            bus_write(3'd4, 32'(v));
            step();
            wait_for(12, 0);
            n_checks++;
            if (seg !== hex_lo[v]) begin n_fail++; $display("FAIL decode v=%0d: got %h want %h", v, seg, hex_lo[v]); end
            n_checks++;
            if (dig_sel !== 6'h3E) begin n_fail++; $display("FAIL decode_sel v=%0d: got %h want 3e", v, dig_sel); end
            bus.address = 3'd0; #1;
            n_checks++;
            if (bus.readdata !== (32'h00FE_DCB0 | 32'(v))) begin
                n_fail++; $display("FAIL nibble_readback v=%0d: got %h want %h", v, bus.readdata, 32'h00FE_DCB0 | 32'(v));
            end
        end
    endtask

    task automatic test_nibble_oob();
        bus_write(3'd4, 32'h0000_0705);
        bus.address = 3'd0; #1;
        n_checks++; if (bus.readdata !== 32'h00FE_DCBF) begin n_fail++; $display("FAIL nibble_oob: got %h want 00fedcbf", bus.readdata); end
        bus.address = 3'd4; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL nibble_read: got %h want 0", bus.readdata); end
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus.address = 3'd5; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL spare_read: got %h want 0", bus.readdata); end
        bus.address = 3'd0; #1;
        n_checks++; if (bus.readdata !== 32'h00FE_DCBF) begin n_fail++; $display("FAIL spare_write: got %h want 00fedcbf", bus.readdata); end
    endtask

    task automatic test_enable();
        logic [7:0] exp_seg [6] = '{8'h8E, 8'hFF, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        logic [5:0] exp_sel [6] = '{6'h3E, 6'h3F, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        bus_write(3'd1, 32'h3D);
        bus.address = 3'd1; #1;
        n_checks++; if (bus.readdata !== 32'h3D) begin n_fail++; $display("FAIL enable_read: got %h want 3d", bus.readdata); end
        step();
        wait_for(12, 0);
        for (int j = 0; j < 12; j++) begin
            int d = j / 2;
            n_checks++;
            if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL enable_seg j=%0d: got %h want %h", j, seg, exp_seg[d]); end
            n_checks++;
            if (dig_sel !== exp_sel[d]) begin n_fail++; $display("FAIL enable_sel j=%0d: got %h want %h", j, dig_sel, exp_sel[d]); end
            step();
        end
        bus_write(3'd1, 32'h3F);
    endtask

    task automatic test_blink_dp();
        int f0;
        bus_write(3'd2, 32'h01);
        bus_write(3'd3, 32'h01);
        step();
        wait_for(12, 0);
        f0 = (cyc - 1) / 12;
        for (int j = 0; j < 24; j++) begin
            if ((j % 12) < 2) begin
                logic       odd;
                logic [7:0] es;
                logic [5:0] ed;
                odd = 1'((f0 + j / 12) % 2);
                es  = odd ? 8'hFF : 8'h0E;
                ed  = odd ? 6'h3F : 6'h3E;
                n_checks++;
                if (seg !== es) begin n_fail++; $display("FAIL blink_seg j=%0d: got %h want %h", j, seg, es); end
                n_checks++;
                if (dig_sel !== ed) begin n_fail++; $display("FAIL blink_sel j=%0d: got %h want %h", j, dig_sel, ed); end
            end
            step();
        end
        bus_write(3'd2, 32'h0);
        bus_write(3'd3, 32'h0);
    endtask

    task automatic test_write_on_tick();
        step();
        wait_for(12, 4);
        // The next edge both ends the digit-2 slot and lands the DATA write.
        bus_write(3'd0, 32'h0012_3456);
        n_checks++; if (seg !== 8'hC6) begin n_fail++; $display("FAIL tick_old_seg: got %h want c6", seg); end
        n_checks++; if (dig_sel !== 6'h3B) begin n_fail++; $display("FAIL tick_old_sel: got %h want 3b", dig_sel); end
        step();
        n_checks++; if (seg !== 8'hB0) begin n_fail++; $display("FAIL tick_new_seg: got %h want b0", seg); end
        n_checks++; if (dig_sel !== 6'h37) begin n_fail++; $display("FAIL tick_new_sel: got %h want 37", dig_sel); end
    endtask

    task automatic test_reset_mid_scan();
        logic [5:0] exp_sel [3] = '{6'h3E, 6'h3E, 6'h3D};
        wait_for(12, 6);
        reset_n = 1'b0;
        #1;
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL midrst_seg: got %h want ff", seg); end
        n_checks++; if (dig_sel !== 6'h3F) begin n_fail++; $display("FAIL midrst_sel: got %h want 3f", dig_sel); end
        bus.address = 3'd0; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", bus.readdata); end
        step();
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            n_checks++;
            if (seg !== 8'hC0) begin n_fail++; $display("FAIL restart_seg j=%0d: got %h want c0", j, seg); end
            n_checks++;
            if (dig_sel !== exp_sel[j]) begin n_fail++; $display("FAIL restart_sel j=%0d: got %h want %h", j, dig_sel, exp_sel[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_nibble_decode();
        test_nibble_oob();
        test_enable();
        test_blink_dp();
        test_write_on_tick();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
